data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Memory-side responder for the single-cycle CPU data port. It services every load and store the core issues on `Mem_WrAddr`/`Mem_WrData`/`MemWrite` and returns load data on `ReadData` in the same cycle. It also provides a word RAM, a 64-bit machine timer with compare interrupt, and an 8-bit console FIFO that drains through a valid/ready port. It sits beside the core in the SoC top, on the far end of the CPU's data interface.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, ≥2.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Mem_WrAddr` in 32: byte address from the CPU, used for loads and stores; bits [1:0] ignored.
- `Mem_WrData` in 32: store data.
- `MemWrite` in 1: store strobe, sampled at the rising edge.
- `ReadData` out 32: combinational load data for `Mem_WrAddr`.
- `timer_irq` out 1: registered machine-timer interrupt.
- `con_valid` out 1: FIFO head is valid.
- `con_data` out 8: FIFO head byte.
- `con_ready` in 1: consumer accepts the head.

## Operation
- Address map (word aligned):
  - RAM at `0x0000_0000` up to `RAM_WORDS*4-1`.
  - `0x8000_0000` MTIME_LO, read-only.
  - `0x8000_0004` MTIME_HI, read-only.
  - `0x8000_0008` MTIMECMP_LO, read/write.
  - `0x8000_000C` MTIMECMP_HI, read/write.
  - `0x8000_0010` CON_DATA: a write pushes `Mem_WrData[7:0]`; reads return 0.
  - `0x8000_0014` CON_STATUS: bit0 full, bit1 empty, bit2 sticky overflow, bits[15:8] occupancy. Any write clears overflow.
- Unmapped addresses: reads return 0; writes are ignored. A RAM index ≥ `RAM_WORDS` counts as unmapped.
- RAM:
  - Asynchronous read.
  - Write at the clock edge when `MemWrite` is high.
  - Contents are not reset.
- Timer:
  - `mtime` is 64 bits and increments every cycle, wrapping at 2^64−1 → 0.
  - `mtimecmp` is 64 bits. Each half-word write updates only that half.
  - `timer_irq` <= (`mtime` ≥ `mtimecmp`), unsigned, using the current register values.
- Console FIFO:
  - Push = store to CON_DATA. Pop = `con_valid && con_ready`.
  - `con_valid` = not empty; `con_data` = head entry.
  - Push while full: data is dropped and overflow is set. Fullness is judged before any same-cycle pop.
  - Push and pop in the same cycle when non-empty and not full: occupancy unchanged, order preserved.
  - No fall-through: a push to an empty FIFO raises `con_valid` one cycle later.
  - Read/write pointers wrap modulo `FIFO_DEPTH`. Occupancy ranges 0..`FIFO_DEPTH`.

## Timing
- Reset values:
  - `mtime` = 0, `mtimecmp` = all ones.
  - `timer_irq` = 0, FIFO empty, overflow = 0.
  - `con_valid` = 0, `con_data` = 0.
  - `ReadData` follows the address combinationally, including during reset.
- Load latency is 0 cycles: `ReadData` is combinational. A read of the same address as a same-cycle store returns the old value.
- Store latency is 1 edge: a new RAM, `mtimecmp` or FIFO value is visible in the next cycle.
- `timer_irq` asserts the edge after `mtime` == `mtimecmp`, observed one cycle after the compare holds. It deasserts one cycle after a `mtimecmp` write moves the compare above `mtime`.
- `reset` mid-operation flushes the FIFO, clears the timer and overflow, and drops a store presented in the same cycle.
- `con_data` must hold steady while `con_valid` is high and `con_ready` is low.

## Structure
- Shared package `mmio_pkg`: map base addresses, register offsets, and CON_STATUS bit positions. The firmware header mirrors it.
- Sub-module `console_fifo`:
  - Parameterised by `FIFO_DEPTH`.
  - Push/full/overflow on one side, valid/ready pop on the other.
  - Exports occupancy.
- The top level owns address decode, the RAM array and the timer.

## Test plan
- RAM: store `0xDEADBEEF` to `0x10`, then load `0x10` and `0x13` → both return `0xDEADBEEF`. Load `0x14` in the same cycle as a store to `0x14` → returns the old value.
- Timer: after reset, write MTIMECMP_HI=0 then MTIMECMP_LO=50 → `timer_irq` rises exactly one cycle after MTIME_LO reads 50. Write MTIMECMP_LO=`0xFFFFFFFF` → irq drops the next cycle.
- Timer carry: force `mtime` to `0x0000_0000_FFFF_FFFE` via a bench hook → MTIME_HI reads 1 two cycles later.
- FIFO order and backpressure: push `0x41`,`0x42`,`0x43` with `con_ready`=0 → CON_STATUS occupancy 3, `con_data`=`0x41` stable. Raise ready → bytes drain in order, then empty=1.
- Overflow: with ready=0, push 9 bytes → full=1, overflow=1, the 9th byte is lost. Write CON_STATUS → overflow=0. Push while full with a simultaneous pop → push still dropped.
- Unmapped and reset: load `0x4000_0000` → 0. Assert `reset` with 5 bytes queued and `mtime`=1000 → next cycle `con_valid`=0, `timer_irq`=0, MTIME_LO=0, RAM contents retained.

Source files
------------

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - data-port memory map, register offsets and console status layout
package mmio_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
  localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] OFF_CON_DATA    = 8'h10;
  localparam logic [7:0] OFF_CON_STATUS  = 8'h14;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_OCC_LSB   = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_CON_DATA,
    SEL_CON_STATUS
  } sel_e;

  function automatic logic [31:0] con_status_word(input logic       full,
                                                  input logic       empty,
                                                  input logic       ovf,
                                                  input logic [7:0] occ);
    logic [31:0] w;
    w                     = '0;
    w[STAT_FULL_BIT]      = full;
    w[STAT_EMPTY_BIT]     = empty;
    w[STAT_OVF_BIT]       = ovf;
    w[STAT_OCC_LSB +: 8]  = occ;
    return w;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// rtl/data_bus_responder_if.sv - CPU data port plus console drain port
interface data_bus_responder_if;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  modport master (
    output Mem_WrAddr, Mem_WrData, MemWrite, con_ready,
    input  ReadData, con_valid, con_data
  );

  modport slave (
    input  Mem_WrAddr, Mem_WrData, MemWrite, con_ready,
    output ReadData, con_valid, con_data
  );
endinterface

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - byte FIFO with drop-on-full, sticky overflow and valid/ready drain
module console_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          ovf_clear,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          tvalid,
  output logic [7:0]                    tdata,
  input  logic                          tready
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (occupancy == (PW+1)'(FIFO_DEPTH));
  assign empty   = (occupancy == '0);
  assign tvalid  = !empty;
  // Head byte only moves on a pop, so it is stable under backpressure.
  assign tdata   = empty ? 8'h00 : mem[rd_ptr];
  assign do_pop  = tvalid && tready;
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (!do_push && do_pop) begin
        occupancy <= occupancy - 1'b1;
      end
      // Fullness is judged before any same-cycle pop.
      if (push && full) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data-port responder: word RAM, 64-bit machine timer, console FIFO
module data_bus_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  data_bus_responder_if.slave   bus,
  output logic                  timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]                 ram [RAM_WORDS];
  logic [63:0]                 mtime;
  logic [63:0]                 mtimecmp;
  sel_e                        sel;
  logic [AW-1:0]               ram_idx;
  logic                        con_full;
  logic                        con_empty;
  logic                        con_ovf;
  logic [$clog2(FIFO_DEPTH):0] con_occ;
  logic                        con_push;
  logic                        con_ovf_clear;
  logic                        unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.Mem_WrAddr[1:0];
  assign ram_idx          = bus.Mem_WrAddr[AW+1:2];

  always_comb begin
    sel = SEL_NONE;
    if (bus.Mem_WrAddr[31:AW+2] == RAM_BASE[31:AW+2]) begin
      sel = SEL_RAM;
    end else if (bus.Mem_WrAddr[31:8] == MMIO_BASE[31:8]) begin
      case ({bus.Mem_WrAddr[7:2], 2'b00})
        OFF_MTIME_LO:    sel = SEL_MTIME_LO;
        OFF_MTIME_HI:    sel = SEL_MTIME_HI;
        OFF_MTIMECMP_LO: sel = SEL_CMP_LO;
        OFF_MTIMECMP_HI: sel = SEL_CMP_HI;
        OFF_CON_DATA:    sel = SEL_CON_DATA;
        OFF_CON_STATUS:  sel = SEL_CON_STATUS;
        default:         sel = SEL_NONE;
      endcase
    end
  end

  // Load path is purely combinational so a load sees pre-edge state.
  always_comb begin
    bus.ReadData = '0;
    case (sel)
      SEL_RAM:        bus.ReadData = ram[ram_idx];
      SEL_MTIME_LO:   bus.ReadData = mtime[31:0];
      SEL_MTIME_HI:   bus.ReadData = mtime[63:32];
      SEL_CMP_LO:     bus.ReadData = mtimecmp[31:0];
      SEL_CMP_HI:     bus.ReadData = mtimecmp[63:32];
      SEL_CON_STATUS: bus.ReadData = con_status_word(con_full, con_empty, con_ovf, 8'(con_occ));
      default:        bus.ReadData = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && bus.MemWrite && sel == SEL_RAM) begin
      ram[ram_idx] <= bus.Mem_WrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime + 64'd1;
      timer_irq <= (mtime >= mtimecmp);
      if (bus.MemWrite && sel == SEL_CMP_LO) begin
        mtimecmp[31:0] <= bus.Mem_WrData;
      end
      if (bus.MemWrite && sel == SEL_CMP_HI) begin
        mtimecmp[63:32] <= bus.Mem_WrData;
      end
    end
  end

  assign con_push      = bus.MemWrite && (sel == SEL_CON_DATA);
  assign con_ovf_clear = bus.MemWrite && (sel == SEL_CON_STATUS);

  console_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (con_push),
    .push_data (bus.Mem_WrData[7:0]),
    .ovf_clear (con_ovf_clear),
    .full      (con_full),
    .empty     (con_empty),
    .overflow  (con_ovf),
    .occupancy (con_occ),
    .tvalid    (bus.con_valid),
    .tdata     (bus.con_data),
    .tready    (bus.con_ready)
  );

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - self-checking bench with a transaction-level reference model
module tb_data_bus_responder;

  localparam int RAM_WORDS  = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_MTIME_LO = 32'h8000_0000;
  localparam logic [31:0] A_MTIME_HI = 32'h8000_0004;
  localparam logic [31:0] A_CMP_LO   = 32'h8000_0008;
  localparam logic [31:0] A_CMP_HI   = 32'h8000_000C;
  localparam logic [31:0] A_CON_DATA = 32'h8000_0010;
  localparam logic [31:0] A_CON_STAT = 32'h8000_0014;

  logic clk = 1'b0;
  logic reset;
  logic timer_irq;

  data_bus_responder_if bus ();

  data_bus_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram_m [int];
  logic [63:0] mtime_m;
  logic [63:0] cmp_m;
  logic        irq_m;
  logic [7:0]  q_m [$];
  logic        ovf_m;

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    logic [31:0] a;
    logic [31:0] st;
    a = {addr[31:2], 2'b00};
    if (a < RAM_WORDS * 4) return ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
    st = 32'h0;
    st[0]    = (q_m.size() == FIFO_DEPTH);
    st[1]    = (q_m.size() == 0);
    st[2]    = ovf_m;
    st[15:8] = 8'(q_m.size());
    case (a)
      A_MTIME_LO: return mtime_m[31:0];
      A_MTIME_HI: return mtime_m[63:32];
      A_CMP_LO:   return cmp_m[31:0];
      A_CMP_HI:   return cmp_m[63:32];
      A_CON_STAT: return st;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] exp_head();
    return (q_m.size() == 0) ? 8'h00 : q_m[0];
  endfunction

  task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic we);
    bus.Mem_WrAddr = addr;
    bus.Mem_WrData = data;
    bus.MemWrite   = we;
  endtask

  // Advances the model by the rules for one clock edge, then the DUT.
  task automatic step();
    logic [31:0] a;
    logic        pop;
    logic        push;
    a    = {bus.Mem_WrAddr[31:2], 2'b00};
    push = 1'b0;
    if (reset) begin
      mtime_m = 64'h0;
      cmp_m   = '1;
      irq_m   = 1'b0;
      ovf_m   = 1'b0;
      q_m.delete();
    end else begin
      pop   = (q_m.size() > 0) && bus.con_ready;
      irq_m = (mtime_m >= cmp_m);
      if (bus.MemWrite) begin
        if (a < RAM_WORDS * 4)  ram_m[int'(a >> 2)] = bus.Mem_WrData;
        else if (a == A_CMP_LO) cmp_m[31:0] = bus.Mem_WrData;
        else if (a == A_CMP_HI) cmp_m[63:32] = bus.Mem_WrData;
        else if (a == A_CON_DATA) begin
          if (q_m.size() == FIFO_DEPTH) ovf_m = 1'b1;
          else push = 1'b1;
        end else if (a == A_CON_STAT) ovf_m = 1'b0;
      end
      mtime_m = mtime_m + 64'd1;
      if (pop) void'(q_m.pop_front());
      if (push) q_m.push_back(bus.Mem_WrData[7:0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.con_ready = 1'b0;
    drive(A_MTIME_LO, 32'h0, 1'b0);
    step();
    step();
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo: got %h expected %h", bus.ReadData, 32'h0); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
    checks++; if (bus.con_valid !== 1'b0) begin errors++; $display("FAIL reset_con_valid: got %b expected 0", bus.con_valid); end
    checks++; if (bus.con_data !== 8'h00) begin errors++; $display("FAIL reset_con_data: got %h expected 00", bus.con_data); end
    drive(A_CMP_HI, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", bus.ReadData); end
    drive(A_CON_STAT, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h expected 00000002", bus.ReadData); end
    reset = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] addr;
    logic [31:0] old;
    drive(32'h10, 32'hDEAD_BEEF, 1'b1);
    step();
    drive(32'h10, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_10: got %h expected deadbeef", bus.ReadData); end
    drive(32'h13, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd_13: got %h expected deadbeef", bus.ReadData); end
    drive(32'h14, 32'h1111_2222, 1'b1);
    step();
    old = exp_rd(32'h14);
    drive(32'h14, 32'h3333_4444, 1'b1);
    #1;
    checks++; if (bus.ReadData !== old) begin errors++; $display("FAIL ram_rd_during_wr: got %h expected %h", bus.ReadData, old); end
    step();
    drive(32'h14, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h3333_4444) begin errors++; $display("FAIL ram_rd_after_wr: got %h expected 33334444", bus.ReadData); end
    for (int i = 0; i < 20; i++) begin
      addr = ($urandom_range(0, RAM_WORDS - 1) << 2) | $urandom_range(0, 3);
      drive(addr, $urandom, 1'b1);
      step();
      drive(addr, 32'h0, 1'b0);
      #1;
      checks++; if (bus.ReadData !== exp_rd(addr)) begin errors++; $display("FAIL ram_random @%h: got %h expected %h", addr, bus.ReadData, exp_rd(addr)); end
    end
  endtask

  task automatic test_timer();
    logic saw50;
    logic prev50;
    do_reset();
    drive(A_CMP_HI, 32'h0, 1'b1);
    step();
    drive(A_CMP_LO, 32'd50, 1'b1);
    step();
    drive(A_MTIME_LO, 32'h0, 1'b0);
    saw50  = 1'b0;
    prev50 = 1'b0;
    for (int i = 0; i < 80 && mtime_m < 64'd56; i++) begin
      #1;
      checks++; if (bus.ReadData !== mtime_m[31:0]) begin errors++; $display("FAIL timer_mtime_lo: got %0d expected %0d", bus.ReadData, mtime_m[31:0]); end
      checks++; if (timer_irq !== irq_m) begin errors++; $display("FAIL timer_irq at mtime %0d: got %b expected %b", mtime_m, timer_irq, irq_m); end
      if (prev50) begin
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_irq_rise: got %b expected 1", timer_irq); end
      end else begin
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_early: got %b expected 0", timer_irq); end
      end
      prev50 = (bus.ReadData == 32'd50) || prev50;
      saw50  = saw50 || (bus.ReadData == 32'd50);
      step();
    end
    checks++; if (saw50 !== 1'b1) begin errors++; $display("FAIL timer_reached_50: got %b expected 1", saw50); end
    drive(A_CMP_LO, 32'hFFFF_FFFF, 1'b1);
    step();
    drive(A_MTIME_LO, 32'h0, 1'b0);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_irq_hold: got %b expected 1", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_drop: got %b expected 0", timer_irq); end
  endtask

  task automatic test_timer_carry();
    force dut.mtime = 64'h0000_0000_FFFF_FFFE;
    mtime_m = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.mtime;
    drive(A_MTIME_HI, 32'h0, 1'b0);
    step();
    step();
    checks++; if (bus.ReadData !== 32'h1) begin errors++; $display("FAIL carry_mtime_hi: got %h expected 00000001", bus.ReadData); end
    drive(A_MTIME_LO, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== exp_rd(A_MTIME_LO)) begin errors++; $display("FAIL carry_mtime_lo: got %h expected %h", bus.ReadData, exp_rd(A_MTIME_LO)); end
    checks++; if (timer_irq !== irq_m) begin errors++; $display("FAIL carry_irq: got %b expected %b", timer_irq, irq_m); end
  endtask

  task automatic test_fifo_order();
    logic [7:0] seq [$];
    do_reset();
    bus.con_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(A_CON_DATA, 32'h41 + i, 1'b1);
      step();
    end
    drive(A_CON_STAT, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ReadData[15:8] !== 8'd3) begin errors++; $display("FAIL fifo_occ3: got %0d expected 3", bus.ReadData[15:8]); end
      checks++; if (bus.con_data !== 8'h41) begin errors++; $display("FAIL fifo_head_stable: got %h expected 41", bus.con_data); end
      step();
    end
    bus.con_ready = 1'b1;
    for (int i = 0; i < 10 && q_m.size() > 0; i++) begin
      checks++; if (bus.con_valid !== 1'b1 || bus.con_data !== q_m[0]) begin errors++; $display("FAIL fifo_drain: got v=%b d=%h expected v=1 d=%h", bus.con_valid, bus.con_data, q_m[0]); end
      seq.push_back(bus.con_data);
      step();
    end
    checks++; if (seq.size() != 3 || seq[0] !== 8'h41 || seq[1] !== 8'h42 || seq[2] !== 8'h43) begin errors++; $display("FAIL fifo_order: got %0d bytes expected 41 42 43", seq.size()); end
    #1;
    checks++; if (bus.ReadData[1] !== 1'b1 || bus.con_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty: got empty=%b valid=%b expected 1 0", bus.ReadData[1], bus.con_valid); end
  endtask

  task automatic test_fifo_random();
    logic we;
    do_reset();
    for (int i = 0; i < 120; i++) begin
      we = ($urandom_range(0, 99) < 55);
      bus.con_ready = ($urandom_range(0, 99) < 40);
      drive(we ? A_CON_DATA : A_CON_STAT, $urandom, we);
      if (!we && $urandom_range(0, 9) == 0) bus.MemWrite = 1'b1;
      #1;
      checks++; if (bus.ReadData !== exp_rd(bus.Mem_WrAddr)) begin errors++; $display("FAIL fifo_rand_rd @%h: got %h expected %h", bus.Mem_WrAddr, bus.ReadData, exp_rd(bus.Mem_WrAddr)); end
      checks++; if (bus.con_valid !== (q_m.size() > 0) || bus.con_data !== exp_head()) begin errors++; $display("FAIL fifo_rand_head: got v=%b d=%h expected v=%b d=%h", bus.con_valid, bus.con_data, q_m.size() > 0, exp_head()); end
      step();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.con_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(A_CON_DATA, 32'h60 + i, 1'b1);
      step();
    end
    drive(A_CON_STAT, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0805) begin errors++; $display("FAIL ovf_status: got %h expected 00000805", bus.ReadData); end
    drive(A_CON_STAT, 32'h0, 1'b1);
    step();
    drive(A_CON_STAT, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0801) begin errors++; $display("FAIL ovf_clear: got %h expected 00000801", bus.ReadData); end
    bus.con_ready = 1'b1;
    drive(A_CON_DATA, 32'hAA, 1'b1);
    step();
    drive(A_CON_STAT, 32'h0, 1'b0);
    bus.con_ready = 1'b0;
    #1;
    checks++; if (bus.ReadData !== 32'h0000_0704) begin errors++; $display("FAIL ovf_push_pop_full: got %h expected 00000704", bus.ReadData); end
    bus.con_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      checks++; if (bus.con_data !== 8'(32'h60 + i) || bus.con_data !== exp_head()) begin errors++; $display("FAIL ovf_drain: got %h expected %h", bus.con_data, 8'(32'h60 + i)); end
      step();
    end
    checks++; if (bus.con_valid !== 1'b0) begin errors++; $display("FAIL ovf_lost_byte: got valid=%b d=%h expected 0", bus.con_valid, bus.con_data); end
  endtask

  task automatic test_unmapped_and_reset();
    logic [31:0] un [4];
    un[0] = 32'h4000_0000; un[1] = 32'h8000_0018; un[2] = A_CON_DATA; un[3] = RAM_WORDS * 4;
    drive(32'h0, 32'h5555_AAAA, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(un[i], 32'hFFFF_FFFF, 1'b1);
      if (un[i] == A_CON_DATA) bus.MemWrite = 1'b0;
      #1;
      checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL unmapped_rd @%h: got %h expected 0", un[i], bus.ReadData); end
      step();
    end
    drive(32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h5555_AAAA) begin errors++; $display("FAIL unmapped_no_alias: got %h expected 5555aaaa", bus.ReadData); end
    do_reset();
    bus.con_ready = 1'b0;
    drive(32'h20, 32'h1234_5678, 1'b1);
    step();
    drive(A_CMP_HI, 32'h0, 1'b1);
    step();
    drive(A_CMP_LO, 32'd10, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(A_CON_DATA, 32'hC0 + i, 1'b1);
      step();
    end
    drive(A_MTIME_LO, 32'h0, 1'b0);
    for (int i = 0; i < 2000 && mtime_m < 64'd1000; i++) step();
    #1;
    checks++; if (bus.ReadData !== 32'd1000 || timer_irq !== 1'b1) begin errors++; $display("FAIL pre_reset: got mtime=%0d irq=%b expected 1000 1", bus.ReadData, timer_irq); end
    reset = 1'b1;
    drive(32'h20, 32'hBAD0_BAD0, 1'b1);
    step();
    reset = 1'b0;
    drive(A_MTIME_LO, 32'h0, 1'b0);
    #1;
    checks++; if (bus.con_valid !== 1'b0) begin errors++; $display("FAIL rst_con_valid: got %b expected 0", bus.con_valid); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", timer_irq); end
    checks++; if (bus.ReadData !== 32'h0) begin errors++; $display("FAIL rst_mtime_lo: got %0d expected 0", bus.ReadData); end
    drive(32'h20, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== 32'h1234_5678) begin errors++; $display("FAIL rst_drops_store: got %h expected 12345678", bus.ReadData); end
    drive(32'h10, 32'h0, 1'b0);
    #1;
    checks++; if (bus.ReadData !== exp_rd(32'h10)) begin errors++; $display("FAIL rst_ram_kept: got %h expected %h", bus.ReadData, exp_rd(32'h10)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.con_ready = 1'b0;
    drive(32'h0, 32'h0, 1'b0);
    mtime_m = 64'h0;
    cmp_m   = '1;
    irq_m   = 1'b0;
    ovf_m   = 1'b0;
    test_reset();
    test_ram();
    test_timer();
    test_timer_carry();
    test_fifo_order();
    test_fifo_random();
    test_overflow();
    test_unmapped_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
